// File: rtl/button_event_pkg.sv
// Shared state encoding and counter sizing for button_event_classifier.
package button_event_pkg;

   typedef enum logic [2:0] {
      IDLE        = 3'd0,
      PRESSED     = 3'd1,
      LONG_HELD   = 3'd2,
      WAIT_GAP    = 3'd3,
      SECOND_HELD = 3'd4
   } btn_state_e;

   // Wide enough to hold the largest terminal count; compares are equality so it never wraps.
   function automatic int unsigned cnt_width(input int unsigned long_c,
                                             input int unsigned gap_c,
                                             input int unsigned rep_c);
      int unsigned max_v;
      max_v = long_c;
      if (gap_c > max_v) max_v = gap_c;
      if (rep_c > max_v) max_v = rep_c;
      return $clog2(max_v + 32'd1);
   endfunction

endpackage

// File: rtl/button_event_classifier.sv
// Classifies debounced presses into short / double / long one-cycle pulses.
// Optional auto-repeat while a long press is held: define BTN_AUTOREPEAT_EN.
module button_event_classifier
   import button_event_pkg::*;
#(
   parameter int unsigned long_cycles   = 100,
   parameter int unsigned gap_cycles    = 50,
   parameter int unsigned repeat_cycles = 25
)(
   input  logic clk,
   input  logic rst,
   input  logic debounced_in,
   output logic short_press,
   output logic double_press,
   output logic long_press,
   output logic repeat_press,
   output logic busy
);

   localparam int unsigned    CW        = cnt_width(long_cycles, gap_cycles, repeat_cycles);
   localparam logic [CW-1:0]  CNT_ZERO  = {CW{1'b0}};
   localparam logic [CW-1:0]  CNT_ONE   = {{(CW-1){1'b0}}, 1'b1};
   localparam logic [CW-1:0]  LONG_LAST = CW'(long_cycles - 32'd1);
   localparam logic [CW-1:0]  GAP_LAST  = CW'(gap_cycles - 32'd1);
`ifdef BTN_AUTOREPEAT_EN
   localparam logic [CW-1:0]  REP_LAST  = CW'(repeat_cycles - 32'd1);
`endif

   btn_state_e    state_r, state_s;
   logic [CW-1:0] cnt_r, cnt_s;
   logic          short_s, double_s, long_s, busy_s;
   logic          short_r, double_r, long_r, busy_r;
`ifdef BTN_AUTOREPEAT_EN
   logic          repeat_s, repeat_r;
`endif

   // State, counter and registered outputs; reset aborts any event in flight.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_r  <= IDLE;
         cnt_r    <= CNT_ZERO;
         short_r  <= 1'b0;
         double_r <= 1'b0;
         long_r   <= 1'b0;
         busy_r   <= 1'b0;
`ifdef BTN_AUTOREPEAT_EN
         repeat_r <= 1'b0;
`endif
      end else begin
         state_r  <= state_s;
         cnt_r    <= cnt_s;
         short_r  <= short_s;
         double_r <= double_s;
         long_r   <= long_s;
         busy_r   <= busy_s;
`ifdef BTN_AUTOREPEAT_EN
         repeat_r <= repeat_s;
`endif
      end
   end

   // Next state and shared counter.
   always_comb begin
      state_s = state_r;
      cnt_s   = cnt_r;
      case (state_r)
         IDLE: begin
            if (debounced_in) begin
               state_s = PRESSED;
               cnt_s   = CNT_ONE;
            end else begin
               state_s = IDLE;
               cnt_s   = CNT_ZERO;
            end
         end
         PRESSED: begin
            if (!debounced_in) begin
               state_s = WAIT_GAP;
               cnt_s   = CNT_ONE;
            end else if (cnt_r == LONG_LAST) begin
               state_s = LONG_HELD;
               cnt_s   = CNT_ZERO;
            end else begin
               state_s = PRESSED;
               cnt_s   = cnt_r + CNT_ONE;
            end
         end
         LONG_HELD: begin
            if (!debounced_in) begin
               state_s = IDLE;
               cnt_s   = CNT_ZERO;
            end else begin
               state_s = LONG_HELD;
`ifdef BTN_AUTOREPEAT_EN
               if (cnt_r == REP_LAST) cnt_s = CNT_ZERO;
               else                   cnt_s = cnt_r + CNT_ONE;
`else
               cnt_s   = cnt_r;
`endif
            end
         end
         WAIT_GAP: begin
            // A new press wins over gap expiry on the same sample.
            if (debounced_in) begin
               state_s = SECOND_HELD;
               cnt_s   = CNT_ZERO;
            end else if (cnt_r == GAP_LAST) begin
               state_s = IDLE;
               cnt_s   = CNT_ZERO;
            end else begin
               state_s = WAIT_GAP;
               cnt_s   = cnt_r + CNT_ONE;
            end
         end
         SECOND_HELD: begin
            if (!debounced_in) state_s = IDLE;
            else               state_s = SECOND_HELD;
            cnt_s = CNT_ZERO;
         end
         default: begin
            state_s = IDLE;
            cnt_s   = CNT_ZERO;
         end
      endcase
   end

   // Event pulses, registered next cycle; at most one is set per sample.
   always_comb begin
      short_s  = 1'b0;
      double_s = 1'b0;
      long_s   = 1'b0;
`ifdef BTN_AUTOREPEAT_EN
      repeat_s = 1'b0;
`endif
      case (state_r)
         PRESSED: begin
            if (debounced_in && (cnt_r == LONG_LAST)) long_s = 1'b1;
            else                                      long_s = 1'b0;
         end
         WAIT_GAP: begin
            if (debounced_in)              double_s = 1'b1;
            else if (cnt_r == GAP_LAST)    short_s  = 1'b1;
            else                           short_s  = 1'b0;
         end
`ifdef BTN_AUTOREPEAT_EN
         LONG_HELD: begin
            if (debounced_in && (cnt_r == REP_LAST)) repeat_s = 1'b1;
            else                                     repeat_s = 1'b0;
         end
`endif
         default: begin
            short_s  = 1'b0;
            double_s = 1'b0;
            long_s   = 1'b0;
         end
      endcase
      busy_s = (state_s != IDLE);
   end

   assign short_press  = short_r;
   assign double_press = double_r;
   assign long_press   = long_r;
   assign busy         = busy_r;
`ifdef BTN_AUTOREPEAT_EN
   assign repeat_press = repeat_r;
`else
   assign repeat_press = 1'b0;
`endif

endmodule

// File: tb/tb_button_event_classifier.sv
// Randomized + directed bench; expectations come from a run-length model of press/gap rules.
module tb_button_event_classifier;

   localparam int LONG = 8;
   localparam int GAP  = 4;
   localparam int REP  = 3;
`ifdef BTN_AUTOREPEAT_EN
   localparam bit AR = 1'b1;
`else
   localparam bit AR = 1'b0;
`endif

   logic clk = 1'b0;
   logic rst = 1'b1;
   logic debounced_in = 1'b0;
   logic short_press, double_press, long_press, repeat_press, busy;

   int tests_run    = 0;
   int tests_failed = 0;

   bit din_q[$];
   bit rst_q[$];
   bit exp_short[], exp_double[], exp_long[], exp_rep[], exp_busy[];

   button_event_classifier #(
      .long_cycles(LONG), .gap_cycles(GAP), .repeat_cycles(REP)
   ) dut (
      .clk(clk), .rst(rst), .debounced_in(debounced_in),
      .short_press(short_press), .double_press(double_press),
      .long_press(long_press), .repeat_press(repeat_press), .busy(busy)
   );

   always #5 clk = ~clk;

   task automatic check_bit(input string tag, input logic obs, input logic exp);
      tests_run++;
      if (obs !== exp) begin
         tests_failed++;
         $display("FAIL %s: got %0b expected %0b", tag, obs, exp);
      end
   endtask

   task automatic add(input bit d, input int n, input bit r);
      for (int k = 0; k < n; k++) begin
         din_q.push_back(d);
         rst_q.push_back(r);
      end
   endtask

   task automatic check_cycle(input int idx);
      check_bit($sformatf("short[%0d]", idx),  short_press,  exp_short[idx]);
      check_bit($sformatf("double[%0d]", idx), double_press, exp_double[idx]);
      check_bit($sformatf("long[%0d]", idx),   long_press,   exp_long[idx]);
      check_bit($sformatf("repeat[%0d]", idx), repeat_press, exp_rep[idx]);
      check_bit($sformatf("busy[%0d]", idx),   busy,         exp_busy[idx]);
   endtask

   initial begin
      int n, i, s, h, r, l;
      bit second;

      // Directed scenarios from the plan, separated by idle lows.
      add(1'b0, 3, 1'b1);
      add(1'b0, 2, 1'b0);
      add(1'b1, 3, 1'b0); add(1'b0, 8, 1'b0);                        // short
      add(1'b1, 3, 1'b0); add(1'b0, 2, 1'b0);
      add(1'b1, 21, 1'b0); add(1'b0, 8, 1'b0);                       // double, no long
      add(1'b1, 28, 1'b0); add(1'b0, 8, 1'b0);                       // long (+repeats)
      add(1'b1, 7, 1'b0);  add(1'b0, 8, 1'b0);                       // just under long
      add(1'b1, 4, 1'b0);  add(1'b1, 1, 1'b1);
      add(1'b1, 10, 1'b0); add(1'b0, 8, 1'b0);                       // reset mid-press
      add(1'b1, 3, 1'b0);  add(1'b0, 3, 1'b0); add(1'b0, 1, 1'b0);   // gap exactly GAP
      add(1'b1, 2, 1'b0);  add(1'b0, 3, 1'b0); add(1'b1, 1, 1'b0);   // second press at last gap slot
      add(1'b0, 6, 1'b0);

      // Random runs biased around the thresholds, with occasional resets.
      for (int it = 0; it < 80; it++) begin
         int hl, ll;
         case ($urandom_range(0, 3))
            0:       hl = LONG - 1;
            1:       hl = LONG + $urandom_range(0, 12);
            default: hl = $urandom_range(1, 6);
         endcase
         ll = ($urandom_range(0, 1) == 0) ? GAP - 1 + $urandom_range(0, 2) : $urandom_range(1, 8);
         add(1'b1, hl, 1'b0);
         if ($urandom_range(0, 15) == 0) add(1'($urandom_range(0, 1)), 1, 1'b1);
         add(1'b0, ll, 1'b0);
      end
      add(1'b0, 10, 1'b0);

      // Reference model: walk high/low runs and apply press, gap and hold rules.
      n = din_q.size();
      exp_short = new[n]; exp_double = new[n]; exp_long = new[n];
      exp_rep = new[n];   exp_busy = new[n];
      i = 0; second = 1'b0;
      while (i < n) begin
         if (rst_q[i]) begin
            second = 1'b0;
            i++;
         end else if (!din_q[i]) begin
            i++;
         end else begin
            s = i; h = 0;
            while (i < n && din_q[i] && !rst_q[i]) begin h++; i++; end
            for (int k = s; k < s + h; k++) exp_busy[k] = 1'b1;
            if (second) begin
               exp_double[s] = 1'b1;
               second = 1'b0;
            end else if (h >= LONG) begin
               exp_long[s + LONG - 1] = 1'b1;
               if (AR)
                  for (int j = s + LONG - 1 + REP; j < s + h; j += REP) exp_rep[j] = 1'b1;
            end else if (i < n && !rst_q[i]) begin
               r = i; l = 0;
               while (i < n && !din_q[i] && !rst_q[i] && l < GAP) begin l++; i++; end
               if (l == GAP) begin
                  exp_short[r + GAP - 1] = 1'b1;
                  for (int k = r; k < r + GAP - 1; k++) exp_busy[k] = 1'b1;
               end else begin
                  for (int k = r; k < r + l; k++) exp_busy[k] = 1'b1;
                  if (i < n && !rst_q[i]) second = 1'b1;
               end
            end
         end
      end

      // Drive on falling edges; check the previous sample's result before changing inputs.
      for (int c = 0; c < n; c++) begin
         @(negedge clk);
         if (c > 0) check_cycle(c - 1);
         debounced_in = din_q[c];
         rst          = rst_q[c];
      end
      @(negedge clk);
      check_cycle(n - 1);

      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule
